soc_system_gpio_pio: RTL and testbench
======================================

Name: soc_system_gpio_pio

Overview:
- Parametrised Avalon-MM slave GPIO, the successor to the single-bit output PIO in soc_system.
- Per-bit direction, synchronised inputs, edge capture with write-1-to-clear, and a maskable level interrupt to the Nios II.
- Zero-wait-state slave on the lightweight bus; pads are driven by the top level from out_port/oe_port.

Parameters:
- DATA_WIDTH, 8, GPIO bit count (1..32).
- RESET_VALUE, 0, reset value of data_out register.
- RESET_DIR, 0, reset value of direction register (1 = output).
- EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 any.
- SYNC_STAGES, 2, input synchroniser depth (2..4).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset, synchronously deasserted upstream.
- address  input  3  register word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data; bits above DATA_WIDTH ignored.
- readdata  output  32  read data, combinational from address; upper bits 0.
- in_port  input  DATA_WIDTH  asynchronous pad inputs.
- out_port  output  DATA_WIDTH  data_out register.
- oe_port  output  DATA_WIDTH  direction register (1 = drive pad).
- irq  output  1  registered interrupt request, active high.

Behaviour:
- Reset (reset_n=0, async): data_out=RESET_VALUE, dir=RESET_DIR, irqmask=0, edgecapture=0, sync chain=0, prev=0, warm-up count=0, irq=0.
- Write condition: chipselect & ~write_n. Register map:
  - addr0: read returns sync_in (last synchroniser stage); write loads data_out.
  - addr1: direction R/W.
  - addr2: irqmask R/W.
  - addr3: read edgecapture; write 1 to a bit clears it, 0 leaves it.
  - addr4/5: see Optional Feature.
  - addr6/7: read 0, writes ignored.
- Synchroniser: SYNC_STAGES flops on in_port; prev = sync_in delayed 1 clk.
- Edge detect (per bit):
  - rise = sync_in & ~prev; fall = ~sync_in & prev; any = rise|fall, selected by EDGE_TYPE.
  - Edge sets the edgecapture bit on the next clk.
  - Latency pad→edgecapture: SYNC_STAGES+1 clks.
- Warm-up: counter counts 0..SYNC_STAGES+1 after reset, then saturates. Edge detection is gated off until saturation, so a pad held high through reset never captures.
- Simultaneous edge and clear on the same bit, same cycle: set wins, bit reads 1.
- Edge detection is independent of direction; output bits still capture their own pad activity.
- irq <= |(edgecapture & irqmask), registered, 1 clk after edgecapture/mask update. Level-sensitive: stays high until all masked bits are cleared or masked.
- No read side effects; readdata valid in the same cycle as address (0 wait states).
- Mid-operation reset: all state returns to reset values immediately and warm-up restarts.

Optional Feature:
- Macro GPIO_PIO_BITSET_EN.
- Defined:
  - addr4 write: data_out |= writedata.
  - addr5 write: data_out &= ~writedata.
  - Both addresses read 0.
  - Single-cycle update, no read-modify-write needed.
- Undefined: addr4/5 behave as reserved (read 0, writes ignored); no set/clear logic synthesised.

Test Plan:
- Reset with DATA_WIDTH=8, RESET_VALUE=8'hA5, RESET_DIR=8'h0F → out_port=A5, oe_port=0F, irq=0, addr3 reads 0. Write addr0=3C → out_port=3C next clk.
- EDGE_TYPE=0, irqmask=01. Pulse in_port[0] 0→1 after warm-up → edgecapture bit0=1 exactly SYNC_STAGES+1 clks later, irq=1 one clk after. Write addr3=01 → edgecapture=0, irq=0 next clk.
- Hold in_port=FF through reset release → edgecapture stays 00 for 20 clks and irq stays 0.
- Rising edge on bit2 in the same cycle as a write of 04 to addr3 → bit2 reads 1.
- EDGE_TYPE=2: toggle in_port[7] 1→0 → capture 80. Mask 00 → irq stays 0. Mask 80 → irq=1.
- GPIO_PIO_BITSET_EN defined, data_out=0F: write addr4=F0 → FF; write addr5=81 → 7E. Macro undefined: same writes leave 0F.

Source files
------------

// File: rtl/soc_system_gpio_pio.sv
// soc_system_gpio_pio: Avalon-MM GPIO with per-bit direction, edge capture and maskable level irq
// Optional feature macro: GPIO_PIO_BITSET_EN adds set (addr4) and clear (addr5) aliases of data_out.
// Ports:
//   clk, reset_n                      system clock, asynchronous active-low reset
//   address, chipselect, write_n      zero-wait-state slave control
//   writedata, readdata               32-bit bus data; bits above DATA_WIDTH ignored / read 0
//   in_port                           asynchronous pad inputs
//   out_port, oe_port                 data_out and direction (1 = drive pad) registers
//   irq                               registered |(edgecapture & irqmask)
module soc_system_gpio_pio #(
    parameter int DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_DIR = '0,
    parameter int EDGE_TYPE = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] oe_port,
    output logic                  irq
);
    localparam int WARM = SYNC_STAGES + 1;
    localparam int CW = $clog2(WARM + 1);
    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
    logic [DATA_WIDTH-1:0] sync_in, prev, data_out, dir, irqmask, edgecap;
    logic [DATA_WIDTH-1:0] wd, edge_hit, edgecap_n, data_out_n;
    logic [CW-1:0] warm_cnt;
    logic warm_done, wr, unused_wd;
    assign wd = writedata[DATA_WIDTH-1:0];
    assign unused_wd = ^writedata;
    assign wr = chipselect & ~write_n;
    assign sync_in = sync_q[SYNC_STAGES-1];
    // The chain and prev start at 0, so a pad held high through reset looks like a rising
    // edge once it reaches sync_in; detection stays off until the chain and prev have filled.
    assign warm_done = warm_cnt == CW'(WARM);
    assign out_port = data_out;
    assign oe_port = dir;
    always_comb begin
        edge_hit = EDGE_TYPE == 0 ? sync_in & ~prev : EDGE_TYPE == 1 ? ~sync_in & prev : sync_in ^ prev;
        // Clear is applied first so a new edge on the same bit in the same cycle wins.
        edgecap_n = (edgecap & ~(wr && address == 3'd3 ? wd : '0)) | (warm_done ? edge_hit : '0);
        data_out_n = wr && address == 3'd0 ? wd : data_out;
`ifdef GPIO_PIO_BITSET_EN
        data_out_n = wr && address == 3'd4 ? data_out | wd : wr && address == 3'd5 ? data_out & ~wd : data_out_n;
`endif
    end
    always_comb begin
        case (address)
            3'd0:    readdata = 32'(sync_in);
            3'd1:    readdata = 32'(dir);
            3'd2:    readdata = 32'(irqmask);
            3'd3:    readdata = 32'(edgecap);
            default: readdata = '0;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            prev     <= '0;
            data_out <= RESET_VALUE;
            dir      <= RESET_DIR;
            irqmask  <= '0;
            edgecap  <= '0;
            warm_cnt <= '0;
            irq      <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], in_port};
            prev     <= sync_in;
            warm_cnt <= warm_done ? warm_cnt : warm_cnt + 1'b1;
            data_out <= data_out_n;
            dir      <= wr && address == 3'd1 ? wd : dir;
            irqmask  <= wr && address == 3'd2 ? wd : irqmask;
            edgecap  <= edgecap_n;
            irq      <= |(edgecap & irqmask);
        end
    end
endmodule

// File: tb/tb_soc_system_gpio_pio.sv
// tb_soc_system_gpio_pio: register table plus edge/irq sequences on a rising-edge and an any-edge instance
module tb_soc_system_gpio_pio;
    localparam int S = 2;
`ifdef GPIO_PIO_BITSET_EN
    localparam logic [7:0] OUT_SET = 8'hFF;
    localparam logic [7:0] OUT_CLR = 8'h7E;
`else
    localparam logic [7:0] OUT_SET = 8'h0F;
    localparam logic [7:0] OUT_CLR = 8'h0F;
`endif
    logic clk = 0, reset_n = 0, chipselect = 0, write_n = 1;
    logic [2:0] address = 0;
    logic [31:0] writedata = 0, rd_a, rd_b;
    logic [7:0] in_a = 0, in_b = 0, out_a, out_b, oe_a, oe_b;
    logic irq_a, irq_b;
    int passed = 0, total = 0;
    typedef struct { string nm; logic [31:0] exp; } sb_t;
    typedef struct { bit wr; logic [2:0] addr; logic [31:0] wdata; logic [31:0] exp_rd; logic [7:0] exp_out; } vec_t;
    sb_t sb[$];
    vec_t v[13];

    always #5 clk = ~clk;

    soc_system_gpio_pio #(.DATA_WIDTH(8), .RESET_VALUE(8'hA5), .RESET_DIR(8'h0F), .EDGE_TYPE(0), .SYNC_STAGES(S)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd_a), .in_port(in_a), .out_port(out_a), .oe_port(oe_a), .irq(irq_a));

    soc_system_gpio_pio #(.DATA_WIDTH(8), .RESET_VALUE(8'hA5), .RESET_DIR(8'h0F), .EDGE_TYPE(2), .SYNC_STAGES(S)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd_b), .in_port(in_b), .out_port(out_b), .oe_port(oe_b), .irq(irq_b));

    task automatic expect_val(input string nm, input logic [31:0] exp);
        sb.push_back('{nm, exp});
    endtask

    task automatic check(input logic [31:0] act);
        sb_t e;
        total++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty: got %0h with nothing expected", act);
            return;
        end
        e = sb.pop_front();
        if (act === e.exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", e.nm, act, e.exp);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        chipselect = 1;
        write_n = 0;
        address = a;
        writedata = d;
        @(posedge clk);
        #1;
        chipselect = 0;
        write_n = 1;
    endtask

    task automatic rd(input logic [2:0] a);
        address = a;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: timeout got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        v = '{
            '{1'b1, 3'd0, 32'h0000_003C, 32'h00, 8'h3C},
            '{1'b1, 3'd1, 32'h0000_00AA, 32'hAA, 8'h3C},
            '{1'b1, 3'd1, 32'h0000_000F, 32'h0F, 8'h3C},
            '{1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFF, 8'h3C},
            '{1'b1, 3'd2, 32'h0000_0000, 32'h00, 8'h3C},
            '{1'b1, 3'd6, 32'hFFFF_FFFF, 32'h00, 8'h3C},
            '{1'b1, 3'd7, 32'h0000_0012, 32'h00, 8'h3C},
            '{1'b1, 3'd0, 32'h0000_000F, 32'h00, 8'h0F},
            '{1'b1, 3'd4, 32'h0000_00F0, 32'h00, OUT_SET},
            '{1'b1, 3'd5, 32'h0000_0081, 32'h00, OUT_CLR},
            '{1'b1, 3'd0, 32'h0000_01FF, 32'h00, 8'hFF},
            '{1'b0, 3'd1, 32'h0000_0000, 32'h0F, 8'hFF},
            '{1'b0, 3'd3, 32'h0000_0000, 32'h00, 8'hFF}
        };
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1;
        expect_val("rst_out", 32'hA5); check(out_a);
        expect_val("rst_oe", 32'h0F); check(oe_a);
        expect_val("rst_irq", 0); check(irq_a);
        rd(3); expect_val("rst_edgecap", 0); check(rd_a);

        foreach (v[i]) begin
            if (v[i].wr) bus_write(v[i].addr, v[i].wdata);
            else begin
                @(posedge clk);
                #1;
            end
            rd(v[i].addr);
            expect_val($sformatf("vec%0d_rd", i), v[i].exp_rd); check(rd_a);
            expect_val($sformatf("vec%0d_out", i), 32'(v[i].exp_out)); check(out_a);
        end

        bus_write(2, 32'h01);
        @(posedge clk);
        #1;
        in_a[0] = 1;
        for (int k = 1; k <= S + 1; k++) begin
            @(posedge clk);
            #1;
            rd(3);
            expect_val($sformatf("latency_clk%0d", k), k <= S ? 32'h0 : 32'h1); check(rd_a);
        end
        expect_val("irq_before_reg", 0); check(irq_a);
        @(posedge clk);
        #1;
        expect_val("irq_rise", 1); check(irq_a);
        bus_write(3, 32'h01);
        rd(3); expect_val("w1c_bit0", 0); check(rd_a);
        @(posedge clk);
        #1;
        expect_val("irq_after_clear", 0); check(irq_a);

        @(posedge clk);
        #1;
        in_a[2] = 1;
        repeat (S - 1) @(posedge clk);
        bus_write(3, 32'h04);
        rd(3); expect_val("set_wins", 32'h04); check(rd_a);
        bus_write(3, 32'h04);
        rd(3); expect_val("clear_bit2", 0); check(rd_a);
        expect_val("unmasked_bit_no_irq", 0); check(irq_a);

        in_a = 8'hFF;
        in_b = 8'hFF;
        @(posedge clk);
        #2;
        reset_n = 0;
        #1;
        expect_val("midrst_out", 32'hA5); check(out_a);
        expect_val("midrst_oe", 32'h0F); check(oe_a);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1;
        rd(2); expect_val("midrst_mask", 0); check(rd_a);
        bus_write(2, 32'hFF);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            rd(3);
            expect_val($sformatf("warm_a_clk%0d", k), 0); check(rd_a);
            expect_val($sformatf("warm_b_clk%0d", k), 0); check(rd_b);
            expect_val($sformatf("warm_irq_clk%0d", k), 0); check(irq_a | irq_b);
        end

        bus_write(2, 32'h00);
        in_a[7] = 0;
        in_b[7] = 0;
        repeat (S + 1) @(posedge clk);
        #1;
        rd(3);
        expect_val("any_fall_b", 32'h80); check(rd_b);
        expect_val("rise_only_a", 0); check(rd_a);
        repeat (2) @(posedge clk);
        #1;
        expect_val("masked_irq_b", 0); check(irq_b);
        bus_write(2, 32'h80);
        expect_val("mask_irq_latency", 0); check(irq_b);
        @(posedge clk);
        #1;
        expect_val("unmask_irq_b", 1); check(irq_b);
        bus_write(3, 32'h80);
        in_a[7] = 1;
        in_b[7] = 1;
        repeat (S + 1) @(posedge clk);
        #1;
        rd(3);
        expect_val("any_rise_b", 32'h80); check(rd_b);
        expect_val("rise_a", 32'h80); check(rd_a);
        bus_write(2, 32'h00);
        @(posedge clk);
        #1;
        expect_val("remask_irq_b", 0); check(irq_b);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
